// File: rtl/temp_conv_sched.sv
// temp_conv_sched: debounces the format button, watches the switches and sequences the shared
// temperature-conversion ROM. Build option TEMP_CLAMP_EN clamps out-of-range inputs to the nearest bound.
module temp_conv_sched #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int ROM_LAT   = 1,
  parameter int MAX_C     = 100,
  parameter int MIN_F     = 32,
  parameter int MAX_F     = 212
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic [7:0] sw,
  output logic [7:0] rom_addr,
  output logic       rom_format,
  input  logic [7:0] rom_data,
  output logic [7:0] in_val,
  output logic [7:0] out_val,
  output logic       fmt,
  output logic       valid,
  output logic       busy,
  output logic       err
);
  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int WW  = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
  localparam logic [7:0] MAX_C8 = 8'(MAX_C);
  localparam logic [7:0] MIN_F8 = 8'(MIN_F);
  localparam logic [7:0] MAX_F8 = 8'(MAX_F);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  logic [1:0]     r_btn_sync;
  logic [7:0]     r_sw_meta;
  logic [7:0]     r_sw_sync;
  logic           r_db_state;
  logic [DBW-1:0] r_db_cnt;
  logic           w_btn_s;
  logic           w_db_accept;
  logic           w_db_rise;

  state_t         r_state;
  logic           r_fmt_req;
  logic           r_pending;
  logic [7:0]     r_last_addr;
  logic [7:0]     r_raw_addr;
  logic [7:0]     r_cur_addr;
  logic           r_cur_fmt;
  logic           r_err_next;
  logic [WW-1:0]  r_wait_cnt;

  logic           w_request;
  logic           w_legal;
  logic [7:0]     w_issue_addr;
  logic           w_cap_go;
  logic [7:0]     w_cap_data;

  // Synchroniser flops carry no reset so sw is already settled when reset releases.
  always_ff @(posedge clk) begin
    r_btn_sync <= {r_btn_sync[0], btn};
    r_sw_meta  <= sw;
    r_sw_sync  <= r_sw_meta;
  end

  assign w_btn_s     = r_btn_sync[1];
  assign w_db_accept = (w_btn_s != r_db_state) && (r_db_cnt == DBW'(DB_CYCLES - 1));
  assign w_db_rise   = w_db_accept && w_btn_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_state <= 1'b0;
      r_db_cnt   <= '0;
    end else if (w_btn_s == r_db_state) begin
      r_db_cnt <= '0;
    end else if (w_db_accept) begin
      r_db_state <= w_btn_s;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_request = (r_sw_sync != r_last_addr) || r_pending;
  assign w_legal   = r_fmt_req ? ((r_sw_sync >= MIN_F8) && (r_sw_sync <= MAX_F8))
                               : (r_sw_sync <= MAX_C8);

`ifdef TEMP_CLAMP_EN
  always_comb begin
    w_issue_addr = r_sw_sync;
    if (!r_fmt_req) begin
      if (r_sw_sync > MAX_C8) w_issue_addr = MAX_C8;
    end else if (r_sw_sync < MIN_F8) begin
      w_issue_addr = MIN_F8;
    end else if (r_sw_sync > MAX_F8) begin
      w_issue_addr = MAX_F8;
    end
  end
`else
  assign w_issue_addr = r_sw_sync;
`endif

  always_comb begin
    w_cap_go   = 1'b0;
    w_cap_data = rom_data;
    if (r_state == S_WAIT && r_wait_cnt == WW'(ROM_LAT - 1)) w_cap_go = 1'b1;
`ifndef TEMP_CLAMP_EN
    if (r_state == S_ISSUE && r_err_next) begin
      w_cap_go   = 1'b1;
      w_cap_data = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_fmt_req   <= 1'b0;
      r_pending   <= 1'b1;
      r_last_addr <= '0;
      r_raw_addr  <= '0;
      r_cur_addr  <= '0;
      r_cur_fmt   <= 1'b0;
      r_err_next  <= 1'b0;
      r_wait_cnt  <= '0;
      rom_addr    <= '0;
      rom_format  <= 1'b0;
      in_val      <= '0;
      out_val     <= '0;
      fmt         <= 1'b0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_state    <= S_ISSUE;
            busy       <= 1'b1;
            r_cur_addr <= w_issue_addr;
            r_raw_addr <= r_sw_sync;
            r_cur_fmt  <= r_fmt_req;
            r_err_next <= !w_legal;
            rom_addr   <= w_issue_addr;
            rom_format <= r_fmt_req;
            r_pending  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
      // Compare against the raw switch value so a clamped input does not retrigger forever.
      if (w_cap_go) begin
        r_state     <= S_CAPTURE;
        in_val      <= r_cur_addr;
        out_val     <= w_cap_data;
        fmt         <= r_cur_fmt;
        err         <= r_err_next;
        valid       <= 1'b1;
        r_last_addr <= r_raw_addr;
      end
      if (w_db_rise) begin
        r_fmt_req <= !r_fmt_req;
        r_pending <= 1'b1;
      end
    end
  end
endmodule
